fp_align_stage: RTL and testbench

FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

---
 rtl/fp_pkg.sv | 28 ++
 rtl/barrel_shifter.sv | 24 ++
 rtl/fp_align_stage.sv | 162 ++++++++++++++++
 tb/tb_fp_align_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default field widths, quiet-NaN constant,
// unpacked-operand struct and the unpack helper used by the alignment stage.
package fp_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = FP_EXP_W + FP_MAN_W + 1;

    localparam logic [FP_W-1:0] FP_QNAN = {1'b0, {FP_EXP_W{1'b1}}, 1'b1, {(FP_MAN_W-1){1'b0}}};

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] eff_exp;
        logic [FP_MAN_W:0]   sig;
    } fp_unp_t;

    // Subnormals use exponent 1 with hidden bit 0 so they align like normals.
    function automatic fp_unp_t fp_unpack(input logic [FP_W-1:0] x);
        fp_unp_t             u;
        logic [FP_EXP_W-1:0] e;
        e         = x[FP_W-2:FP_MAN_W];
        u.sign    = x[FP_W-1];
        u.eff_exp = (e == '0) ? FP_EXP_W'(1) : e;
        u.sig     = {(e != '0), x[FP_MAN_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Right shift of {data_in,2'b00} by shamt with a sticky OR of every bit shifted out.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Guard field is as wide as the largest shift, so no shifted-out bit is ever lost.
module barrel_shifter #(
    parameter int WIDTH   = 24,
    parameter int SHIFT_W = 5
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHIFT_W-1:0] shamt,
    output logic [WIDTH+1:0]   data_out,
    output logic               sticky
);

    localparam int GUARD = (1 << SHIFT_W) - 1;

    logic [WIDTH+1+GUARD:0] ext;

    always_comb begin
        ext      = {data_in, 2'b00, {GUARD{1'b0}}} >> shamt;
        data_out = ext[WIDTH+1+GUARD:GUARD];
        sticky   = |ext[GUARD-1:0];
    end

endmodule

// File: rtl/fp_align_stage.sv
// FP add/sub operand alignment: pick larger magnitude, right-align the smaller with sticky.
// Latency: 2 cycles (S1 unpack/compare, S2 shift). Backpressure: valid/ready, each stage
// advances when empty or drained; optional NaN/Inf detection under FP_ALIGN_SPECIAL_EN.
module fp_align_stage
    import fp_pkg::*;
#(
    parameter int EXP_W = FP_EXP_W,
    parameter int MAN_W = FP_MAN_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   op_a,
    input  logic [EXP_W+MAN_W:0]   op_b,
    input  logic                   sub_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MAN_W+2:0]       big_mant,
    output logic [MAN_W+2:0]       small_mant,
    output logic                   sticky,
    output logic [EXP_W-1:0]       exp_big,
    output logic                   sign_big,
    output logic                   eff_sub,
    output logic                   special,
    output logic [EXP_W+MAN_W:0]   special_res
);

    localparam int W = EXP_W + MAN_W + 1;
    localparam int M = MAN_W + 3;

    typedef struct packed {
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   big_sig;
        logic [MAN_W:0]   small_sig;
        logic [4:0]       shift;
        logic             sign;
        logic             eff_sub;
        logic             special;
        logic [W-1:0]     special_res;
    } s1_t;

    typedef struct packed {
        logic [M-1:0]     big_mant;
        logic [M-1:0]     small_mant;
        logic             sticky;
        logic [EXP_W-1:0] exp;
        logic             sign;
        logic             eff_sub;
        logic             special;
        logic [W-1:0]     special_res;
    } s2_t;

    logic s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic s2_free, s1_free;

    // The unpacked struct follows the package widths; overriding EXP_W/MAN_W
    // needs a matching fp_pkg.
    fp_unp_t          ua, ub, ubig;
    logic             a_big;
    logic [EXP_W-1:0] small_exp, diff;
    logic [MAN_W:0]   small_sig;
    logic             eff_sub_c;

    logic [M-1:0]     sh_mant;
    logic             sh_sticky;

    assign s2_free  = !s2_vld_q || out_ready;
    assign s1_free  = !s1_vld_q || s2_free;
    assign in_ready = s1_free;

    always_comb begin
        ua        = fp_unpack(op_a);
        ub        = fp_unpack(op_b);
        a_big     = (op_a[W-2:0] >= op_b[W-2:0]);
        ubig      = a_big ? ua : ub;
        small_exp = a_big ? ub.eff_exp : ua.eff_exp;
        small_sig = a_big ? ub.sig : ua.sig;
        diff      = ubig.eff_exp - small_exp;
        eff_sub_c = op_a[W-1] ^ op_b[W-1] ^ sub_op;

        s1_vld_d = s1_free ? in_valid : s1_vld_q;
        s1_d     = s1_q;
        if (s1_free && in_valid) begin
            s1_d.exp         = ubig.eff_exp;
            s1_d.big_sig     = ubig.sig;
            s1_d.small_sig   = small_sig;
            s1_d.shift       = (diff > EXP_W'(31)) ? 5'd31 : diff[4:0];
            s1_d.sign        = ubig.sign ^ (!a_big && sub_op);
            s1_d.eff_sub     = eff_sub_c;
            s1_d.special     = 1'b0;
            s1_d.special_res = '0;
`ifdef FP_ALIGN_SPECIAL_EN
            if ((&op_a[W-2:MAN_W] && |op_a[MAN_W-1:0]) ||
                (&op_b[W-2:MAN_W] && |op_b[MAN_W-1:0]) ||
                (&op_a[W-2:MAN_W] && &op_b[W-2:MAN_W] && eff_sub_c)) begin
                s1_d.special     = 1'b1;
                s1_d.special_res = FP_QNAN;
            end else if (&op_a[W-2:MAN_W]) begin
                s1_d.special     = 1'b1;
                s1_d.special_res = {op_a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else if (&op_b[W-2:MAN_W]) begin
                s1_d.special     = 1'b1;
                s1_d.special_res = {op_b[W-1] ^ sub_op, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end
`endif
        end
    end

    barrel_shifter #(
        .WIDTH  (MAN_W + 1),
        .SHIFT_W(5)
    ) u_shift (
        .data_in (s1_q.small_sig),
        .shamt   (s1_q.shift),
        .data_out(sh_mant),
        .sticky  (sh_sticky)
    );

    always_comb begin
        s2_vld_d = s2_free ? s1_vld_q : s2_vld_q;
        s2_d     = s2_q;
        if (s2_free && s1_vld_q) begin
            s2_d.big_mant    = {s1_q.big_sig, 2'b00};
            s2_d.small_mant  = sh_mant;
            s2_d.sticky      = sh_sticky;
            s2_d.exp         = s1_q.exp;
            s2_d.sign        = s1_q.sign;
            s2_d.eff_sub     = s1_q.eff_sub;
            s2_d.special     = s1_q.special;
            s2_d.special_res = s1_q.special_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

    assign out_valid   = s2_vld_q;
    assign big_mant    = s2_q.big_mant;
    assign small_mant  = s2_q.small_mant;
    assign sticky      = s2_q.sticky;
    assign exp_big     = s2_q.exp;
    assign sign_big    = s2_q.sign;
    assign eff_sub     = s2_q.eff_sub;
    assign special     = s2_q.special;
    assign special_res = s2_q.special_res;

endmodule

// File: tb/tb_fp_align_stage.sv
// Bench for fp_align_stage: directed vector table, stall/reset sequences and
// randomized traffic against an arithmetic reference model.
module tb_fp_align_stage;

`ifdef FP_ALIGN_SPECIAL_EN
    localparam bit SPEC_EN = 1'b1;
`else
    localparam bit SPEC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub_op, out_valid, out_ready;
    logic [31:0] op_a, op_b, special_res;
    logic [25:0] big_mant, small_mant;
    logic        sticky, sign_big, eff_sub, special;
    logic [7:0]  exp_big;

    always #5 clk = ~clk;

    fp_align_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub_op(sub_op), .out_valid(out_valid),
        .out_ready(out_ready), .big_mant(big_mant), .small_mant(small_mant),
        .sticky(sticky), .exp_big(exp_big), .sign_big(sign_big), .eff_sub(eff_sub),
        .special(special), .special_res(special_res)
    );

    typedef struct packed {
        logic [25:0] big_mant;
        logic [25:0] small_mant;
        logic        sticky;
        logic [7:0]  exp_big;
        logic        sign_big;
        logic        eff_sub;
        logic        special;
        logic [31:0] special_res;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        res_t        r;
    } vec_t;

    typedef struct {
        res_t r;
        int   acc;
    } pend_t;

    pend_t q[$];
    vec_t  vt[8];
    res_t  pending_r, hold_r;
    int    checks = 0, failures = 0, cyc = 0, n_out = 0, pat_i = 0, ordy_mode = 0;
    bit    chk_lat = 0, chk_inrdy = 0, hold_vld = 0, acc_flag = 0;
    logic  ordy_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got=%0h required=%0h", name, got, req);
        end
    endtask

    function automatic res_t dut_res();
        return {big_mant, small_mant, sticky, exp_big, sign_big, eff_sub, special, special_res};
    endfunction

    function automatic res_t mk(input logic [25:0] bm, input logic [25:0] sm, input logic st,
                                input logic [7:0] e, input logic sb, input logic es,
                                input logic sp, input logic [31:0] sr);
        return {bm, sm, st, e, sb, es, sp & SPEC_EN, SPEC_EN ? sr : 32'h0};
    endfunction

    // Reference: magnitudes as integers, alignment by division/remainder.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t   r;
        int     ea, eb, xa, xb, xbig, xsml, sh;
        longint ma, mb, mbig, msml, v;
        bit     a_big, na, nb, ia, ib;
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        xa    = (ea == 0) ? 1 : ea;
        xb    = (eb == 0) ? 1 : eb;
        ma    = longint'(a[22:0]) + ((ea != 0) ? 64'd8388608 : 64'd0);
        mb    = longint'(b[22:0]) + ((eb != 0) ? 64'd8388608 : 64'd0);
        a_big = (a[30:0] >= b[30:0]);
        xbig  = a_big ? xa : xb;
        xsml  = a_big ? xb : xa;
        mbig  = a_big ? ma : mb;
        msml  = a_big ? mb : ma;
        sh    = (xbig - xsml > 31) ? 31 : xbig - xsml;
        v     = msml * 4;
        r.big_mant    = 26'(mbig * 4);
        r.small_mant  = 26'(v / (longint'(1) << sh));
        r.sticky      = (v % (longint'(1) << sh)) != 0;
        r.exp_big     = 8'(xbig);
        r.sign_big    = a_big ? a[31] : (b[31] ^ sub);
        r.eff_sub     = a[31] ^ b[31] ^ sub;
        r.special     = 1'b0;
        r.special_res = 32'h0;
        if (SPEC_EN) begin
            na = (ea == 255) && (a[22:0] != 0);
            nb = (eb == 255) && (b[22:0] != 0);
            ia = (ea == 255) && (a[22:0] == 0);
            ib = (eb == 255) && (b[22:0] == 0);
            if (na || nb || (ia && ib && r.eff_sub)) begin
                r.special = 1'b1; r.special_res = 32'h7FC00000;
            end else if (ia) begin
                r.special = 1'b1; r.special_res = {a[31], 8'hFF, 23'h0};
            end else if (ib) begin
                r.special = 1'b1; r.special_res = {b[31] ^ sub, 8'hFF, 23'h0};
            end
        end
        return r;
    endfunction

    // One clock: observe at the falling edge, then update out_ready after the rising edge.
    task automatic tick();
        pend_t p;
        @(negedge clk);
        if (hold_vld) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_data", dut_res(), hold_r);
        end
        hold_vld = out_valid && !out_ready;
        if (hold_vld) hold_r = dut_res();
        if (chk_inrdy) chk("in_ready_streaming", in_ready, 1);
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got out_valid=1 required no pending op");
            end else begin
                p = q.pop_front();
                chk("result", dut_res(), p.r);
                if (chk_lat) chk("latency", 128'(cyc - p.acc), 2);
                n_out++;
            end
        end
        if (in_valid && in_ready) begin
            q.push_back('{r: pending_r, acc: cyc});
            acc_flag = 1'b1;
        end
        cyc++;
        @(posedge clk);
        #1;
        if (ordy_mode == 1) begin
            out_ready = ordy_pat[pat_i];
            pat_i     = (pat_i + 1) % 4;
        end else if (ordy_mode == 2) begin
            out_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s, input res_t r);
        in_valid  = 1'b1;
        op_a      = a;
        op_b      = b;
        sub_op    = s;
        pending_r = r;
        acc_flag  = 1'b0;
        for (int i = 0; i < 200 && !acc_flag; i++) tick();
        if (!acc_flag) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got in_ready=0 for 200 cycles required acceptance");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        ordy_mode = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() > 0; i++) tick();
        chk("drain_empty", 128'(q.size()), 0);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          n0;

        vt[0] = '{32'h40000000, 32'h3F800000, 1'b0, mk(26'h2000000, 26'h1000000, 0, 8'h80, 0, 0, 0, 0)};
        vt[1] = '{32'h3F800001, 32'h4C000000, 1'b0, mk(26'h2000000, 26'h0000001, 1, 8'h98, 0, 0, 0, 0)};
        vt[2] = '{32'h3F800000, 32'h3F800000, 1'b1, mk(26'h2000000, 26'h2000000, 0, 8'h7F, 0, 1, 0, 0)};
        vt[3] = '{32'h7F800000, 32'h7F800000, 1'b1, mk(26'h2000000, 26'h2000000, 0, 8'hFF, 0, 1, 1, 32'h7FC00000)};
        vt[4] = '{32'h3F800000, 32'hC0000000, 1'b1, mk(26'h2000000, 26'h1000000, 0, 8'h80, 0, 0, 0, 0)};
        vt[5] = '{32'h00000001, 32'h7F000000, 1'b0, mk(26'h2000000, 26'h0000000, 1, 8'hFE, 0, 0, 0, 0)};
        vt[6] = '{32'hFF800000, 32'h3F800000, 1'b0, mk(26'h2000000, 26'h0000000, 1, 8'hFF, 1, 1, 1, 32'hFF800000)};
        vt[7] = '{32'h00000003, 32'h00000002, 1'b1, mk(26'h000000C, 26'h0000008, 0, 8'h01, 0, 1, 0, 0)};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = 32'h0;
        op_b      = 32'h0;
        sub_op    = 1'b0;
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", dut_res(), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("in_ready_after_reset", in_ready, 1);

        // Directed table, streamed back-to-back with out_ready high.
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        chk_inrdy = 1'b1;
        n0        = n_out;
        for (int i = 0; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].sub, vt[i].r);
        chk_inrdy = 1'b0;
        drain();
        chk_lat = 1'b0;
        chk("table_count", 128'(n_out - n0), 8);

        // Eight back-to-back ops with out_ready cycling 1,0,0,1.
        ordy_mode = 1;
        pat_i     = 1;
        out_ready = ordy_pat[0];
        n0        = n_out;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            b[30:23] = a[30:23] - 8'(i * 3);
            s = 1'(i);
            send(a, b, s, model(a, b, s));
        end
        drain();
        chk("stall_seq_count", 128'(n_out - n0), 8);

        // Randomized traffic with random gaps and random backpressure.
        ordy_mode = 2;
        n0        = n_out;
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                1: b[30:23] = a[30:23] + 8'($urandom_range(0, 30));
                2: b[30:23] = 8'h00;
                3: a[30:0] = b[30:0];
                4: a[30:23] = 8'hFF;
                default: ;
            endcase
            s = 1'($urandom_range(0, 1));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            send(a, b, s, model(a, b, s));
        end
        drain();
        chk("random_count", 128'(n_out - n0), 300);

        // Fill both stages under backpressure, then reset mid-flight.
        ordy_mode = 0;
        out_ready = 1'b0;
        send(vt[1].a, vt[1].b, vt[1].sub, vt[1].r);
        send(vt[2].a, vt[2].b, vt[2].sub, vt[2].r);
        chk("pre_reset_full", {out_valid, in_ready}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_outputs", dut_res(), 0);
        q.delete();
        hold_vld = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("in_ready_after_mid_reset", in_ready, 1);
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        n0        = n_out;
        send(vt[0].a, vt[0].b, vt[0].sub, vt[0].r);
        drain();
        chk_lat = 1'b0;
        chk("post_reset_count", 128'(n_out - n0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
